// File: rtl/test_monitor.sv
// Test monitor: waits for the CPU pc to settle, then checks up to NUM_CHECKS registers against a table.
// Latency: CHECK follows STABLE_CYCLES unchanged-pc cycles; done rises NUM_CHECKS cycles later (or after TIMEOUT run cycles).
// Backpressure: none; start is ignored while busy, and so are table writes.
module test_monitor #(
  parameter int WIDTH         = 32,
  parameter int NUM_CHECKS    = 4,
  parameter int IDX_W         = 2,
  parameter int STABLE_CYCLES = 8,
  parameter int TIMEOUT       = 10000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] pc,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic             cfg_en,
  input  logic [4:0]       cfg_reg,
  input  logic [WIDTH-1:0] cfg_val,
  output logic [4:0]       rd_addr,
  input  logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             passed,
  output logic             timed_out,
  output logic [IDX_W:0]   fail_count,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic [WIDTH-1:0] first_fail_data
);

  localparam int CYC_W  = $clog2(TIMEOUT + 1);
  localparam int HALT_W = $clog2(STABLE_CYCLES + 1);

  localparam logic [IDX_W:0]    NCHK     = (IDX_W + 1)'(NUM_CHECKS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CHECKS - 1);
  localparam logic [CYC_W-1:0]  TO_VAL   = CYC_W'(TIMEOUT);
  localparam logic [HALT_W-1:0] HALT_VAL = HALT_W'(STABLE_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [HALT_W-1:0] halt_q, halt_d;
  logic [WIDTH-1:0]  pc_prev_q, pc_prev_d;
  logic              first_q, first_d;
  logic [IDX_W-1:0]  chk_idx_q, chk_idx_d;
  logic [IDX_W:0]    fail_count_q, fail_count_d;
  logic [IDX_W-1:0]  ffi_q, ffi_d;
  logic [WIDTH-1:0]  ffd_q, ffd_d;
  logic              timed_out_q, timed_out_d;

  logic [NUM_CHECKS-1:0] tbl_en_q, tbl_en_d;
  logic [4:0]            tbl_reg_q [NUM_CHECKS];
  logic [4:0]            tbl_reg_d [NUM_CHECKS];
  logic [WIDTH-1:0]      tbl_val_q [NUM_CHECKS];
  logic [WIDTH-1:0]      tbl_val_d [NUM_CHECKS];

  logic             busy_int;
  logic             cur_en;
  logic [4:0]       cur_reg;
  logic [WIDTH-1:0] cur_val;

  assign busy_int = (state_q == S_RUN) || (state_q == S_CHECK);

  // Table entry currently under check.
  always_comb begin
    cur_en  = 1'b0;
    cur_reg = 5'd0;
    cur_val = '0;
    for (int k = 0; k < NUM_CHECKS; k++) begin
      if (chk_idx_q == IDX_W'(k)) begin
        cur_en  = tbl_en_q[k];
        cur_reg = tbl_reg_q[k];
        cur_val = tbl_val_q[k];
      end
    end
  end

  // Table writes: only when idle or done, and only for entries that exist.
  always_comb begin
    tbl_en_d  = tbl_en_q;
    tbl_reg_d = tbl_reg_q;
    tbl_val_d = tbl_val_q;
    if (cfg_we && !busy_int && ({1'b0, cfg_idx} < NCHK)) begin
      for (int k = 0; k < NUM_CHECKS; k++) begin
        if (cfg_idx == IDX_W'(k)) begin
          tbl_en_d[k]  = cfg_en;
          tbl_reg_d[k] = cfg_reg;
          tbl_val_d[k] = cfg_val;
        end
      end
    end
  end

  // FSM next state, run/halt counting and result accumulation.
  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    halt_d       = halt_q;
    pc_prev_d    = pc_prev_q;
    first_d      = first_q;
    chk_idx_d    = chk_idx_q;
    fail_count_d = fail_count_q;
    ffi_d        = ffi_q;
    ffd_d        = ffd_q;
    timed_out_d  = timed_out_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_RUN;
          cyc_d        = '0;
          halt_d       = '0;
          first_d      = 1'b1;
          chk_idx_d    = '0;
          fail_count_d = '0;
          ffi_d        = '0;
          ffd_d        = '0;
          timed_out_d  = 1'b0;
        end
      end
      S_RUN: begin
        cyc_d     = cyc_q + CYC_W'(1);
        first_d   = 1'b0;
        pc_prev_d = pc;
        // The first run cycle has no previous pc, so it counts as a change.
        if (!first_q && (pc == pc_prev_q)) begin
          halt_d = halt_q + HALT_W'(1);
        end else begin
          halt_d = '0;
        end
        // Halt detection takes priority over a coincident timeout.
        if (halt_d == HALT_VAL) begin
          state_d   = S_CHECK;
          chk_idx_d = '0;
        end else if (cyc_d == TO_VAL) begin
          state_d     = S_DONE;
          timed_out_d = 1'b1;
        end
      end
      S_CHECK: begin
        if (cur_en && (rd_data != cur_val)) begin
          if (fail_count_q < NCHK) begin
            fail_count_d = fail_count_q + (IDX_W + 1)'(1);
          end
          if (fail_count_q == '0) begin
            ffi_d = chk_idx_q;
            ffd_d = rd_data;
          end
        end
        if (chk_idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          chk_idx_d = chk_idx_q + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and table registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cyc_q        <= '0;
      halt_q       <= '0;
      pc_prev_q    <= '0;
      first_q      <= 1'b0;
      chk_idx_q    <= '0;
      fail_count_q <= '0;
      ffi_q        <= '0;
      ffd_q        <= '0;
      timed_out_q  <= 1'b0;
      tbl_en_q     <= '0;
      for (int k = 0; k < NUM_CHECKS; k++) begin
        tbl_reg_q[k] <= '0;
        tbl_val_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      halt_q       <= halt_d;
      pc_prev_q    <= pc_prev_d;
      first_q      <= first_d;
      chk_idx_q    <= chk_idx_d;
      fail_count_q <= fail_count_d;
      ffi_q        <= ffi_d;
      ffd_q        <= ffd_d;
      timed_out_q  <= timed_out_d;
      tbl_en_q     <= tbl_en_d;
      tbl_reg_q    <= tbl_reg_d;
      tbl_val_q    <= tbl_val_d;
    end
  end

  assign rd_addr         = (state_q == S_CHECK) ? cur_reg : 5'd0;
  assign busy            = busy_int;
  assign done            = (state_q == S_DONE);
  assign passed          = (state_q == S_DONE) && (fail_count_q == '0) && !timed_out_q;
  assign timed_out       = timed_out_q;
  assign fail_count      = fail_count_q;
  assign first_fail_idx  = ffi_q;
  assign first_fail_data = ffd_q;

endmodule
